// File: rtl/matmul_pkg.sv
// Shared constants for the matrix-multiplier memory path: core count,
// noc clamp limits and the request-collector state encoding.
package matmul_pkg;

    localparam int NUM_CORES = 4;

    localparam logic [3:0] NOC_MIN = 4'd1;
    localparam logic [3:0] NOC_MAX = 4'd4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    // A core count of zero still means core 0 is working.
    function automatic logic [2:0] clamp_noc(input logic [3:0] n);
        if (n < NOC_MIN)
            return NOC_MIN[2:0];
        else if (n > NOC_MAX)
            return NOC_MAX[2:0];
        else
            return n[2:0];
    endfunction

    function automatic logic [NUM_CORES-1:0] active_mask(input logic [2:0] n);
        logic [NUM_CORES-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_CORES; k++)
            m[k] = (k < int'(n));
        return m;
    endfunction

endpackage

// File: rtl/addr_compare_unit.sv
// Flags whether any active core addresses a location other than core 0's.
module addr_compare_unit #(
    parameter int ADDR_W = 8,
    parameter int NUM    = 4
) (
    input  logic [NUM*ADDR_W-1:0] addr,
    input  logic [NUM-1:0]        mask,
    output logic                  diff
);

    always_comb begin
        diff = 1'b0;
        for (int k = 1; k < NUM; k++) begin
            if (mask[0] && mask[k] && (addr[k*ADDR_W +: ADDR_W] != addr[0 +: ADDR_W]))
                diff = 1'b1;
        end
    end

endmodule

// File: rtl/mem_request_collector.sv
// Collects lock-step core memory requests, issues one read/write command to
// the control unit, stalls for its occupancy and releases the cores.
module mem_request_collector
    import matmul_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    noc,
    input  logic [NUM_CORES-1:0]          core_rd_req,
    input  logic [NUM_CORES-1:0]          core_wr_req,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    output logic [1:0]                    read,
    output logic [1:0]                    write,
    output logic [NUM_CORES-1:0]          core_done,
    output logic                          busy,
    output logic                          proto_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]           state;
    logic [2:0]           noc_q;
    logic [NUM_CORES-1:0] mask_q;
    logic                 kind_wr;
    logic [TW-1:0]        tcnt;
    logic [2:0]           wait_cnt;

    logic [2:0]           noc_now;
    logic [NUM_CORES-1:0] mask_now;
    logic                 start_req;
    logic [NUM_CORES-1:0] kind_req;
    logic [NUM_CORES-1:0] opp_req;
    logic                 all_req;
    logic                 opp_seen;
    logic                 drained;
    logic                 diff;

    addr_compare_unit #(
        .ADDR_W (ADDR_W),
        .NUM    (NUM_CORES)
    ) u_cmp (
        .addr (core_addr),
        .mask (mask_q),
        .diff (diff)
    );

    // Once an operation starts, all decisions use the mask captured in IDLE.
    always_comb begin
        noc_now   = clamp_noc(noc);
        mask_now  = active_mask(noc_now);
        start_req = |((core_rd_req | core_wr_req) & mask_now);
        kind_req  = kind_wr ? core_wr_req : core_rd_req;
        opp_req   = kind_wr ? core_rd_req : core_wr_req;
        all_req   = ((kind_req & mask_q) == mask_q);
        opp_seen  = |(opp_req & mask_q);
        drained   = ((core_rd_req | core_wr_req) & mask_q) == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            noc_q     <= '0;
            mask_q    <= '0;
            kind_wr   <= 1'b0;
            tcnt      <= '0;
            wait_cnt  <= '0;
            read      <= 2'b00;
            write     <= 2'b00;
            core_done <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            read      <= 2'b00;
            write     <= 2'b00;
            core_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state   <= ST_COLLECT;
                        noc_q   <= noc_now;
                        mask_q  <= mask_now;
                        kind_wr <= |(core_wr_req & mask_now);
                        tcnt    <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (opp_seen) begin
                        proto_err <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (all_req) begin
                        state <= ST_ISSUE;
                        if (kind_wr)
                            write <= {diff, 1'b1};
                        else
                            read  <= {diff, 1'b1};
                        wait_cnt <= diff ? noc_q : 3'd1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        proto_err <= 1'b1;
                        state     <= ST_DRAIN;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                // The control unit is busy for wait_cnt cycles after the command.
                ST_WAIT: begin
                    if (wait_cnt <= 3'd1) begin
                        wait_cnt  <= '0;
                        core_done <= mask_q;
                        state     <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_collector.sv
// Directed bench for mem_request_collector with hand-computed expectations.
module tb_mem_request_collector;

    logic        clk;
    logic        rst;
    logic [3:0]  noc;
    logic [3:0]  core_rd_req;
    logic [3:0]  core_wr_req;
    logic [31:0] core_addr;
    logic [1:0]  read;
    logic [1:0]  write;
    logic [3:0]  core_done;
    logic        busy;
    logic        proto_err;

    int checks;
    int errors;

    mem_request_collector #(
        .ADDR_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .noc         (noc),
        .core_rd_req (core_rd_req),
        .core_wr_req (core_wr_req),
        .core_addr   (core_addr),
        .read        (read),
        .write       (write),
        .core_done   (core_done),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        noc         = 4'd1;
        core_rd_req = 4'b0000;
        core_wr_req = 4'b0000;
        core_addr   = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rst = 1'b1;
        clear_inputs();
        step();
        outs = {read, write, core_done, busy, proto_err};
        checks++;
        if (outs !== 11'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 11'b0);
        end
        core_rd_req = 4'b1111;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_holds_idle: busy got %b expected 0", busy);
        end
        core_rd_req = 4'b0000;
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single_core();
        noc         = 4'd1;
        core_addr   = 32'h0000_0010;
        core_rd_req = 4'b0001;
        step();
        checks++;
        if (busy !== 1'b1 || read !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_collect: busy=%b read=%b expected busy=1 read=00", busy, read);
        end
        step();
        checks++;
        if (read !== 2'b01 || write !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_issue: read=%b write=%b expected read=01 write=00", read, write);
        end
        step();
        checks++;
        if (read !== 2'b00 || core_done !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_wait: read=%b done=%b expected 00/0000", read, core_done);
        end
        step();
        checks++;
        if (core_done !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_done: got %b expected 0001", core_done);
        end
        core_rd_req = 4'b0000;
        step();
        checks++;
        if (core_done !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_drain: done=%b busy=%b expected 0000/1", core_done, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_same_addr_write();
        noc         = 4'd4;
        core_addr   = 32'h2222_2222;
        core_wr_req = 4'b1111;
        step();
        step();
        checks++;
        if (write !== 2'b01 || read !== 2'b00) begin
            errors++;
            $display("[TB] FAIL same_issue: write=%b read=%b expected write=01 read=00", write, read);
        end
        step();
        checks++;
        if (write !== 2'b00 || core_done !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL same_wait: write=%b done=%b expected 00/0000", write, core_done);
        end
        step();
        checks++;
        if (core_done !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL same_done: got %b expected 1111", core_done);
        end
        core_wr_req = 4'b0000;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_diff_addr_read();
        noc         = 4'd3;
        core_addr   = 32'hFF03_0201;
        core_rd_req = 4'b0111;
        core_wr_req = 4'b1000;
        step();
        step();
        checks++;
        if (read !== 2'b11 || write !== 2'b00) begin
            errors++;
            $display("[TB] FAIL diff_issue: read=%b write=%b expected read=11 write=00", read, write);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (core_done !== 4'b0000 || read !== 2'b00) begin
                errors++;
                $display("[TB] FAIL diff_wait%0d: done=%b read=%b expected 0000/00", i, core_done, read);
            end
        end
        step();
        checks++;
        if (core_done !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL diff_done: got %b expected 0111", core_done);
        end
        core_rd_req = 4'b0000;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL diff_idle: busy got %b expected 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || write !== 2'b00) begin
            errors++;
            $display("[TB] FAIL inactive_core_ignored: busy=%b write=%b expected 0/00", busy, write);
        end
        core_wr_req = 4'b0000;
    endtask

    task automatic test_noc_clamp();
        noc         = 4'd0;
        core_addr   = 32'h0000_9910;
        core_rd_req = 4'b0011;
        step();
        step();
        checks++;
        if (read !== 2'b01) begin
            errors++;
            $display("[TB] FAIL clamp_zero_issue: read got %b expected 01", read);
        end
        step();
        step();
        checks++;
        if (core_done !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL clamp_zero_done: got %b expected 0001", core_done);
        end
        core_rd_req = 4'b0000;
        step();
        step();
        noc         = 4'd9;
        core_addr   = 32'h4433_2211;
        core_rd_req = 4'b1111;
        step();
        step();
        checks++;
        if (read !== 2'b11) begin
            errors++;
            $display("[TB] FAIL clamp_high_issue: read got %b expected 11", read);
        end
        noc = 4'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (core_done !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL clamp_high_wait%0d: done got %b expected 0000", i, core_done);
            end
        end
        step();
        checks++;
        if (core_done !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL clamp_high_done: got %b expected 1111", core_done);
        end
        core_rd_req = 4'b0000;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_conflict();
        noc         = 4'd2;
        core_addr   = 32'h0;
        core_rd_req = 4'b0001;
        core_wr_req = 4'b0010;
        step();
        step();
        checks++;
        if (proto_err !== 1'b1 || read !== 2'b00 || write !== 2'b00) begin
            errors++;
            $display("[TB] FAIL conflict_err: err=%b read=%b write=%b expected 1/00/00", proto_err, read, write);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || read !== 2'b00 || write !== 2'b00) begin
                errors++;
                $display("[TB] FAIL conflict_hold%0d: busy=%b read=%b write=%b expected 1/00/00", i, busy, read, write);
            end
        end
        core_rd_req = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_partial_drop: busy got %b expected 1", busy);
        end
        core_wr_req = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_idle: busy=%b err=%b expected 0/1", busy, proto_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        noc         = 4'd4;
        core_addr   = 32'h0;
        core_rd_req = 4'b0111;
        step();
        for (int i = 2; i <= 15; i++) begin
            step();
            checks++;
            if (read !== 2'b00 || proto_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_early%0d: read=%b err=%b expected 00/0", i, read, proto_err);
            end
        end
        step();
        checks++;
        if (proto_err !== 1'b1 || read !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_err: err=%b read=%b busy=%b expected 1/00/1", proto_err, read, busy);
        end
        core_rd_req = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [10:0] outs;
        do_reset();
        noc         = 4'd4;
        core_addr   = 32'h4030_2010;
        core_rd_req = 4'b1111;
        step();
        step();
        checks++;
        if (read !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midrst_issue: read got %b expected 11", read);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b1 || core_done !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_wait: busy=%b done=%b expected 1/0000", busy, core_done);
        end
        rst = 1'b1;
        #1;
        outs = {read, write, core_done, busy, proto_err};
        checks++;
        if (outs !== 11'b0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got %b expected %b", outs, 11'b0);
        end
        core_rd_req = 4'b0000;
        step();
        rst = 1'b0;
        step();
        core_addr   = 32'h5555_5555;
        core_rd_req = 4'b1111;
        step();
        step();
        checks++;
        if (read !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midrst_fresh_issue: read got %b expected 01", read);
        end
        step();
        step();
        checks++;
        if (core_done !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL midrst_fresh_done: got %b expected 1111", core_done);
        end
        core_rd_req = 4'b0000;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_fresh_idle: busy=%b err=%b expected 0/0", busy, proto_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        $display("[TB] starting mem_request_collector bench");
        test_reset();
        test_single_core();
        test_same_addr_write();
        test_diff_addr_read();
        test_noc_clamp();
        test_conflict();
        test_timeout();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
